// File: rtl/sv32_ptw_pkg.sv
// sv32_ptw_pkg: Sv32 PTE layout, walker state encoding and PTE classification helpers
package sv32_ptw_pkg;
    localparam int VPN_WIDTH                 = 20;
    localparam int PPN_WIDTH                 = 22;
    localparam int PA_WIDTH                  = 34;
    localparam int ITLB_L2_TLB_REQ_TAG_WIDTH = 2;
    localparam int PTW_PTE_SIZE_BITS         = 2;
    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d, a, g, u, x, w, r, v;
    } pte_t;
    typedef logic [2:0] ptw_state_t;
    localparam ptw_state_t PTW_IDLE    = 3'd0;
    localparam ptw_state_t PTW_L1_REQ  = 3'd1;
    localparam ptw_state_t PTW_L1_WAIT = 3'd2;
    localparam ptw_state_t PTW_L0_REQ  = 3'd3;
    localparam ptw_state_t PTW_L0_WAIT = 3'd4;
    localparam ptw_state_t PTW_RESP    = 3'd5;
    function automatic logic pte_is_leaf(pte_t p);
        return p.r | p.x;
    endfunction
    function automatic logic pte_is_invalid(pte_t p);
        return !p.v || (!p.r && p.w);
    endfunction
    // level=1 is the root table; a pointer there is legal, at level 0 it is not
    function automatic logic pte_fault(pte_t p, logic level, logic check_a);
        return pte_is_invalid(p) ||
               (pte_is_leaf(p) ? ((level && p.ppn0 != '0) || (check_a && !p.a)) : !level);
    endfunction
endpackage

// File: rtl/sv32_pte_check.sv
// sv32_pte_check: classifies one PTE at a given level into leaf / superpage / fault
module sv32_pte_check
    import sv32_ptw_pkg::*;
#(
    parameter bit CHECK_A = 1'b1
) (
    input  logic [31:0] i_pte,
    input  logic        i_level,
    output logic        o_leaf,
    output logic        o_fault,
    output logic        o_superpage
);
    pte_t w_pte;
    assign w_pte       = pte_t'(i_pte);
    assign o_leaf      = pte_is_leaf(w_pte);
    assign o_superpage = o_leaf & i_level;
    assign o_fault     = pte_fault(w_pte, i_level, CHECK_A);
endmodule

// File: rtl/sv32_ptw.sv
// sv32_ptw: two-level Sv32 page table walker with a single-outstanding PTE read port
module sv32_ptw
    import sv32_ptw_pkg::*;
#(
    parameter int TAG_WIDTH = ITLB_L2_TLB_REQ_TAG_WIDTH,
    parameter bit CHECK_A   = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [VPN_WIDTH-1:0] req_vpn,
    input  logic [PPN_WIDTH-1:0] satp_ppn,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [PA_WIDTH-1:0]  mem_req_pa,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_pte,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [TAG_WIDTH-1:0] resp_tag,
    output logic [31:0]          resp_pte,
    output logic                 resp_superpage,
    output logic                 resp_page_fault
);
    ptw_state_t             r_state;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [VPN_WIDTH-1:0]   r_vpn;
    logic [PPN_WIDTH-1:0]   r_root;
    pte_t                   r_pte;
    logic                   r_super;
    logic                   r_fault;
    logic                   w_leaf;
    logic                   w_fault;
    logic                   w_super;

    sv32_pte_check #(.CHECK_A(CHECK_A)) u_check (
        .i_pte       (mem_resp_pte),
        .i_level     (r_state == PTW_L1_WAIT),
        .o_leaf      (w_leaf),
        .o_fault     (w_fault),
        .o_superpage (w_super)
    );

    assign req_ready       = r_state == PTW_IDLE;
    assign mem_req_valid   = (r_state == PTW_L1_REQ) || (r_state == PTW_L0_REQ);
    assign mem_req_pa      = (r_state == PTW_L1_REQ)
                           ? {r_root, r_vpn[19:10], {PTW_PTE_SIZE_BITS{1'b0}}}
                           : {r_pte.ppn1, r_pte.ppn0, r_vpn[9:0], {PTW_PTE_SIZE_BITS{1'b0}}};
    assign resp_valid      = r_state == PTW_RESP;
    assign resp_tag        = r_tag;
    assign resp_pte        = r_pte;
    assign resp_superpage  = r_super;
    assign resp_page_fault = r_fault;

    // r_pte doubles as the L0 table pointer and the reported PTE
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= PTW_IDLE;
            r_tag   <= '0;
            r_vpn   <= '0;
            r_root  <= '0;
            r_pte   <= '0;
            r_super <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                PTW_IDLE: if (req_valid) begin
                    r_tag   <= req_tag;
                    r_vpn   <= req_vpn;
                    r_root  <= satp_ppn;
                    r_state <= PTW_L1_REQ;
                end
                PTW_L1_REQ: if (mem_req_ready) r_state <= PTW_L1_WAIT;
                PTW_L0_REQ: if (mem_req_ready) r_state <= PTW_L0_WAIT;
                PTW_L1_WAIT, PTW_L0_WAIT: if (mem_resp_valid) begin
                    r_pte   <= pte_t'(mem_resp_pte);
                    r_super <= w_super;
                    r_fault <= w_fault;
                    r_state <= (w_fault || w_leaf) ? PTW_RESP : PTW_L0_REQ;
                end
                PTW_RESP: if (resp_ready) r_state <= PTW_IDLE;
                default: r_state <= PTW_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sv32_ptw.sv
// tb_sv32_ptw: scoreboard bench with a queued PTE memory model and a response monitor
module tb_sv32_ptw;
    logic        CLK, RST;
    logic        req_valid, req_ready;
    logic [1:0]  req_tag;
    logic [19:0] req_vpn;
    logic [21:0] satp_ppn;
    logic        mem_req_valid, mem_req_ready;
    logic [33:0] mem_req_pa;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_pte;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_tag;
    logic [31:0] resp_pte;
    logic        resp_superpage, resp_page_fault;

    sv32_ptw dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_vpn(req_vpn), .satp_ppn(satp_ppn),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_pa(mem_req_pa),
        .mem_resp_valid(mem_resp_valid), .mem_resp_pte(mem_resp_pte),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
        .resp_pte(resp_pte), .resp_superpage(resp_superpage), .resp_page_fault(resp_page_fault)
    );

    typedef struct { logic [33:0] pa; logic [31:0] pte; bit respond; } mem_t;
    typedef struct { logic [1:0] tag; logic [31:0] pte; logic sp; logic pf; } rsp_t;
    mem_t mq[$];
    rsp_t sq[$];
    int   n_chk = 0, n_fail = 0, n_hs = 0;
    int   mstall = 0, rstall = 0;
    bit   inject = 0, pend = 0;
    logic [31:0] pend_pte = '0;

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // memory model: one-cycle read latency, optional request stall
    initial begin
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_pte = '0;
        forever begin
            @(negedge CLK);
            mem_resp_valid = pend || inject;
            mem_resp_pte   = inject ? 32'h000C00CF : pend_pte;
            pend = 0; inject = 0;
            mem_req_ready = (mstall == 0);
            if (mem_req_valid) begin
                if (mq.size() == 0) chk("mem_unexpected_read", {30'b0, mem_req_pa}, 64'h0);
                else begin
                    chk("mem_pa", {30'b0, mem_req_pa}, {30'b0, mq[0].pa});
                    if (mem_req_ready) begin
                        pend = mq[0].respond; pend_pte = mq[0].pte;
                        void'(mq.pop_front());
                    end else mstall--;
                end
            end
        end
    end

    // response monitor
    initial begin
        resp_ready = 1;
        forever begin
            @(negedge CLK);
            resp_ready = (rstall == 0);
            if (resp_valid) begin
                chk("req_ready_during_resp", {63'b0, req_ready}, 64'h0);
                if (sq.size() == 0) chk("unexpected_resp", {63'b0, resp_valid}, 64'h0);
                else begin
                    chk("resp", {29'b0, resp_tag, resp_pte, resp_superpage, resp_page_fault},
                        {29'b0, sq[0].tag, sq[0].pte, sq[0].sp, sq[0].pf});
                    if (resp_ready) begin void'(sq.pop_front()); n_hs++; end
                    else rstall--;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] tag, input logic [19:0] vpn, input int min_hs);
        int n = 0;
        @(negedge CLK);
        req_valid = 1; req_tag = tag; req_vpn = vpn; satp_ppn = 22'h10;
        while (!req_ready && n < 200) begin @(negedge CLK); n++; end
        chk("accept_timeout", {63'b0, req_ready}, 64'h1);
        chk("accept_after_prior_resp", {63'b0, n_hs >= min_hs}, 64'h1);
        @(posedge CLK);
        #1 req_valid = 0; satp_ppn = 22'h3FFFFF;
    endtask

    task automatic walk(input logic [1:0] tag, input logic [19:0] vpn, input int nreads,
                        input logic [33:0] pa0, input logic [31:0] d0,
                        input logic [33:0] pa1, input logic [31:0] d1,
                        input logic [31:0] epte, input logic esp, input logic epf, input int min_hs);
        mq.push_back('{pa: pa0, pte: d0, respond: 1'b1});
        if (nreads == 2) mq.push_back('{pa: pa1, pte: d1, respond: 1'b1});
        sq.push_back('{tag: tag, pte: epte, sp: esp, pf: epf});
        issue(tag, vpn, min_hs);
    endtask

    task automatic lat(input string name, input int exp);
        int k = 0;
        do begin @(negedge CLK); k++; end while (!resp_valid && k < 50);
        chk(name, 64'(k), 64'(exp));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && (sq.size() != 0 || mq.size() != 0); i++) @(negedge CLK);
        @(negedge CLK);
        chk("walk_done", {63'b0, sq.size() == 0 && mq.size() == 0}, 64'h1);
    endtask

    initial begin
        int h0;
        RST = 1; req_valid = 0; req_tag = '0; req_vpn = '0; satp_ppn = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 0;
        @(negedge CLK);
        chk("rst_req_ready", {63'b0, req_ready}, 64'h1);
        chk("rst_mem_req_valid", {63'b0, mem_req_valid}, 64'h0);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'h0);
        chk("rst_resp_fields", {29'b0, resp_tag, resp_pte, resp_superpage, resp_page_fault}, 64'h0);

        walk(2'd2, 20'h00401, 2, 34'h10004, 32'h00008001, 34'h20004, 32'h000C00CF, 32'h000C00CF, 0, 0, 0);
        lat("latency_4k", 5);
        wait_done();
        walk(2'd1, 20'h00401, 1, 34'h10004, 32'h001000CF, 34'h0, 32'h0, 32'h001000CF, 1, 0, 0);
        lat("latency_4m", 3);
        wait_done();
        walk(2'd3, 20'h00401, 1, 34'h10004, 32'h001004CF, 34'h0, 32'h0, 32'h001004CF, 1, 1, 0);
        wait_done();
        walk(2'd0, 20'h00401, 1, 34'h10004, 32'h00008000, 34'h0, 32'h0, 32'h00008000, 0, 1, 0);
        wait_done();
        walk(2'd1, 20'h00802, 2, 34'h10008, 32'h00008001, 34'h20008, 32'h000C008F, 32'h000C008F, 0, 1, 0);
        wait_done();
        walk(2'd2, 20'h00802, 2, 34'h10008, 32'h00008001, 34'h20008, 32'h00008001, 32'h00008001, 0, 1, 0);
        wait_done();

        // memory and response backpressure, second request queued behind the first
        mstall = 5; rstall = 3; h0 = n_hs;
        walk(2'd3, 20'h00401, 2, 34'h10004, 32'h00008001, 34'h20004, 32'h000C00CF, 32'h000C00CF, 0, 0, h0);
        walk(2'd0, 20'h00401, 1, 34'h10004, 32'h001000CF, 34'h0, 32'h0, 32'h001000CF, 1, 0, h0 + 1);
        wait_done();
        chk("mstall_consumed", 64'(mstall), 64'h0);
        chk("rstall_consumed", 64'(rstall), 64'h0);

        // reset while waiting for the L0 PTE, then a stray response beat
        mq.push_back('{pa: 34'h10004, pte: 32'h00008001, respond: 1'b1});
        mq.push_back('{pa: 34'h20004, pte: 32'h0, respond: 1'b0});
        issue(2'd2, 20'h00401, 0);
        for (int i = 0; i < 50 && mq.size() != 0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        chk("pre_reset_busy", {63'b0, req_ready}, 64'h0);
        RST = 1;
        @(posedge CLK);
        #1 RST = 0; inject = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_reset_state", {61'b0, req_ready, resp_valid, mem_req_valid}, 64'h4);
        end
        walk(2'd1, 20'h00401, 2, 34'h10004, 32'h00008001, 34'h20004, 32'h000C00CF, 32'h000C00CF, 0, 0, 0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
